bullet_collider: RTL

Scans the bullet table once per game frame, tests each live bullet's bounding box against the player's heart box, and reports the result back to the bullet store. It sits directly downstream of the bullet store's second read port (`index2`/`position2`/`size2`/`color2`/`isRender2`) and upstream of that store's `indexCollide`/`isComplete` inputs. It also feeds per-frame damage and heal counts to the HP logic.

---
 rtl/bullet_collider.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bullet_collider.sv
// bullet_collider: once per frame, walks the bullet table through the store's
// second read port, tests every live bullet against the player's heart box and
// returns a new render mask plus per-frame damage and heal counts.
module bullet_collider #(
  parameter int NUM_BULLETS = 3,
  parameter int IDX_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              isRun,
  input  logic              scanStart,
  input  logic [15:0]       playerPos,
  input  logic [15:0]       playerSize,
  input  logic              playerMoving,
  output logic [IDX_W-1:0]  index,
  input  logic [15:0]       position,
  input  logic [15:0]       size,
  input  logic [1:0]        color,
  input  logic              isRender,
  output logic [IDX_W-1:0]  indexCollide,
  output logic              isComplete,
  output logic [1:0]        damage,
  output logic [1:0]        heal,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BULLETS - 1);

  localparam logic [1:0] COLOR_WHITE = 2'd0;
  localparam logic [1:0] COLOR_GREEN = 2'd1;
  localparam logic [1:0] COLOR_BLUE  = 2'd2;
  localparam logic [1:0] COLOR_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] scr_mask_q, scr_mask_d;
  logic [1:0]       scr_dmg_q, scr_dmg_d;
  logic [1:0]       scr_heal_q, scr_heal_d;
  logic [IDX_W-1:0] collide_q, collide_d;
  logic [1:0]       damage_q, damage_d;
  logic [1:0]       heal_q, heal_d;
  logic             complete_q, complete_d;
  logic             busy_q, busy_d;

  // Box edges widened to 9 bits so x+w never wraps back into the screen.
  logic [8:0] p_x, p_y, p_x_end, p_y_end;
  logic [8:0] b_x, b_y, b_x_end, b_y_end;
  logic       overlap_x, overlap_y;
  logic       slot_hit, slot_keep, slot_dmg, slot_heal;
  logic [1:0] dmg_sum, heal_sum;

  assign p_x     = {1'b0, playerPos[15:8]};
  assign p_y     = {1'b0, playerPos[7:0]};
  assign p_x_end = p_x + {1'b0, playerSize[15:8]};
  assign p_y_end = p_y + {1'b0, playerSize[7:0]};
  assign b_x     = {1'b0, position[15:8]};
  assign b_y     = {1'b0, position[7:0]};
  assign b_x_end = b_x + {1'b0, size[15:8]};
  assign b_y_end = b_y + {1'b0, size[7:0]};

  // Strict overlap: boxes that merely touch along an edge do not collide.
  assign overlap_x = (b_x < p_x_end) && (p_x < b_x_end);
  assign overlap_y = (b_y < p_y_end) && (p_y < b_y_end);

  // The reserved colour is treated as harmless scenery.
  assign slot_hit  = isRender && (color != COLOR_RSVD) && overlap_x && overlap_y;
  assign slot_keep = isRender && !slot_hit;
  assign slot_dmg  = slot_hit && ((color == COLOR_WHITE) ||
                                  ((color == COLOR_BLUE) && playerMoving));
  assign slot_heal = slot_hit && (color == COLOR_GREEN);

  // Three hits at most, so a 2-bit count cannot overflow.
  assign dmg_sum  = scr_dmg_q + {1'b0, slot_dmg};
  assign heal_sum = scr_heal_q + {1'b0, slot_heal};

  // Per-lane merge of the current slot's verdict into the scratch mask.
  logic [IDX_W-1:0] slot_sel;
  logic [IDX_W-1:0] mask_upd;

  generate
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_lane
      assign slot_sel[gi] = (index_q == IDX_W'(gi));
      assign mask_upd[gi] = slot_sel[gi] ? slot_keep : scr_mask_q[gi];
    end
  endgenerate

  // Next-state and next-output logic for the IDLE/SCAN/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    scr_mask_d = scr_mask_q;
    scr_dmg_d  = scr_dmg_q;
    scr_heal_d = scr_heal_q;
    collide_d  = collide_q;
    damage_d   = damage_q;
    heal_d     = heal_q;
    complete_d = 1'b0;

    if (!isRun) begin
      // Game paused: abandon any scan and present a "nothing hit" result.
      state_d    = ST_IDLE;
      index_d    = '0;
      scr_mask_d = '0;
      scr_dmg_d  = '0;
      scr_heal_d = '0;
      collide_d  = '1;
      damage_d   = '0;
      heal_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (scanStart) begin
            state_d    = ST_SCAN;
            index_d    = '0;
            scr_mask_d = '0;
            scr_dmg_d  = '0;
            scr_heal_d = '0;
          end
        end
        ST_SCAN: begin
          scr_mask_d = mask_upd;
          scr_dmg_d  = dmg_sum;
          scr_heal_d = heal_sum;
          if (index_q == LAST_IDX) begin
            // Publish results together with the completion pulse.
            state_d    = ST_DONE;
            index_d    = '0;
            collide_d  = mask_upd;
            damage_d   = dmg_sum;
            heal_d     = heal_sum;
            complete_d = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          index_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          index_d = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // All state and outputs are flops, so isComplete and busy are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      scr_mask_q <= '0;
      scr_dmg_q  <= '0;
      scr_heal_q <= '0;
      collide_q  <= '1;
      damage_q   <= '0;
      heal_q     <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      scr_mask_q <= scr_mask_d;
      scr_dmg_q  <= scr_dmg_d;
      scr_heal_q <= scr_heal_d;
      collide_q  <= collide_d;
      damage_q   <= damage_d;
      heal_q     <= heal_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
    end
  end

  assign index        = index_q;
  assign indexCollide = collide_q;
  assign isComplete   = complete_q;
  assign damage       = damage_q;
  assign heal         = heal_q;
  assign busy         = busy_q;

endmodule
